keypad_entry: RTL and testbench

Front-end stage of the numeric keypad path: scans a 4x4 matrix keypad, debounces it, decodes presses to 4-bit key codes, and accumulates up to four decimal digits as BCD. Its bcd3..bcd0 outputs feed the BCD-to-binary converter directly; num_valid marks a completed entry.

---
 rtl/keypad_entry.sv | 209 ++++++++++++++++++++
 tb/tb_keypad_entry.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad front end: row scanner, frame-based debouncer, key decoder and a
// four-digit BCD entry register feeding the BCD-to-binary converter.
module keypad_entry #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic [3:0] bcd3,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic [2:0] digit_count,
  output logic       num_valid
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [0:0] {StIdle, StHeld} db_state_e;

  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_lut = 4'h1;
      4'h1: key_lut = 4'h2;
      4'h2: key_lut = 4'h3;
      4'h3: key_lut = 4'hA;
      4'h4: key_lut = 4'h4;
      4'h5: key_lut = 4'h5;
      4'h6: key_lut = 4'h6;
      4'h7: key_lut = 4'hB;
      4'h8: key_lut = 4'h7;
      4'h9: key_lut = 4'h8;
      4'hA: key_lut = 4'h9;
      4'hB: key_lut = 4'hC;
      4'hC: key_lut = 4'hE;
      4'hD: key_lut = 4'h0;
      4'hE: key_lut = 4'hF;
      4'hF: key_lut = 4'hD;
    endcase
  endfunction

  logic [3:0]    col_s1_q, col_s2_q;
  logic [1:0]    row_idx_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic          sample, frame_end;
  logic [2:0]    row_hits, hit_sum;
  logic [1:0]    hit_col;
  logic          fr_key, fr_multi;

  assign sample    = (dwell_q == DW'(SCAN_DIV - 1));
  assign frame_end = sample && (row_idx_q == 2'd3);
  assign row       = 4'b0001 << row_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q   <= '0;
      col_s2_q   <= '0;
      row_idx_q  <= '0;
      dwell_q    <= '0;
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else begin
      col_s1_q <= col;
      col_s2_q <= col_s1_q;
      if (sample) begin
        dwell_q    <= '0;
        row_idx_q  <= row_idx_q + 2'd1;
        acc_cnt_q  <= frame_end ? 2'd0 : acc_cnt_d;
        acc_code_q <= frame_end ? 4'd0 : acc_code_d;
      end else begin
        dwell_q <= dwell_q + DW'(1);
      end
    end
  end

  // Hit count across the frame saturates at 2: anything above one key is MULTI.
  always_comb begin
    hit_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (col_s2_q[i]) hit_col = 2'(i);
    end
    row_hits = {2'b0, col_s2_q[0]} + {2'b0, col_s2_q[1]} + {2'b0, col_s2_q[2]}
             + {2'b0, col_s2_q[3]};
    hit_sum    = {1'b0, acc_cnt_q} + row_hits;
    acc_cnt_d  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    acc_code_d = (acc_cnt_q == 2'd0 && row_hits == 3'd1) ? key_lut(row_idx_q, hit_col)
                                                          : acc_code_q;
  end

  assign fr_key   = (acc_cnt_d == 2'd1);
  assign fr_multi = (acc_cnt_d == 2'd2);

  db_state_e     state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d, cnt_inc;
  logic          prev_key_q, prev_key_d;
  logic [3:0]    prev_code_q, prev_code_d;
  logic          same, press;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      db_cnt_q    <= '0;
      prev_key_q  <= 1'b0;
      prev_code_q <= '0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      prev_key_q  <= prev_key_d;
      prev_code_q <= prev_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    prev_key_d  = prev_key_q;
    prev_code_d = prev_code_q;
    same        = (fr_key == prev_key_q) && (!fr_key || fr_code_eq());
    if (!same)                            cnt_inc = CW'(1);
    else if (db_cnt_q == CW'(DEBOUNCE))   cnt_inc = db_cnt_q;
    else                                  cnt_inc = db_cnt_q + CW'(1);
    if (frame_end) begin
      if (fr_multi) begin
        db_cnt_d   = '0;
        prev_key_d = 1'b0;
      end else begin
        db_cnt_d    = cnt_inc;
        prev_key_d  = fr_key;
        prev_code_d = acc_code_d;
      end
      unique case (state_q)
        StIdle: if (fr_key && cnt_inc == CW'(DEBOUNCE)) state_d = StHeld;
        StHeld: if (!fr_key && !fr_multi && cnt_inc == CW'(DEBOUNCE)) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  function automatic logic fr_code_eq();
    fr_code_eq = (acc_code_d == prev_code_q);
  endfunction

  always_comb begin
    press = frame_end && (state_q == StIdle) && fr_key && (cnt_inc == CW'(DEBOUNCE));
  end

  logic [3:0]  key_code_q;
  logic        key_strobe_q, num_valid_q, done_q;
  logic [15:0] bcd_q;
  logic [2:0]  count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_code_q   <= '0;
      key_strobe_q <= 1'b0;
    end else begin
      key_strobe_q <= press;
      if (press) key_code_q <= acc_code_d;
    end
  end

  // A digit after a completed entry starts a fresh number even when four are held.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q       <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      num_valid_q <= 1'b0;
    end else begin
      num_valid_q <= 1'b0;
      if (key_strobe_q) begin
        if (key_code_q <= 4'd9) begin
          if (done_q) begin
            bcd_q   <= {12'h000, key_code_q};
            count_q <= 3'd1;
            done_q  <= 1'b0;
          end else if (count_q != 3'd4) begin
            bcd_q   <= {bcd_q[11:0], key_code_q};
            count_q <= count_q + 3'd1;
          end
        end else if (key_code_q == 4'hE) begin
          bcd_q   <= '0;
          count_q <= '0;
          done_q  <= 1'b0;
        end else if (key_code_q == 4'hF) begin
          num_valid_q <= 1'b1;
          done_q      <= 1'b1;
        end
      end
    end
  end

  assign key_code    = key_code_q;
  assign key_strobe  = key_strobe_q;
  assign bcd3        = bcd_q[15:12];
  assign bcd2        = bcd_q[11:8];
  assign bcd1        = bcd_q[7:4];
  assign bcd0        = bcd_q[3:0];
  assign digit_count = count_q;
  assign num_valid   = num_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a keypad model drives col from row, stimulus queues
// the expected key and entry state, and a monitor checks them when a strobe appears.
module tb_keypad_entry;

  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col;
  logic [3:0] row, key_code, bcd3, bcd2, bcd1, bcd0;
  logic       key_strobe, num_valid;
  logic [2:0] digit_count;
  logic [15:0] pressed = '0;

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row), .key_code(key_code),
    .key_strobe(key_strobe), .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .digit_count(digit_count), .num_valid(num_valid)
  );

  always #5 clk = ~clk;

  // Matrix keypad: a pressed key connects its row drive to its column.
  always_comb begin
    col = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row[r] && pressed[r*4+c]) col[c] = 1'b1;
  end

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] bcd;
    logic [2:0]  cnt;
    logic        nv;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  logic pending = 1'b0;
  int   checks = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pending = 1'b0;
    end else if (pending) begin
      check("bcd", {16'h0, bcd3, bcd2, bcd1, bcd0}, {16'h0, pend.bcd});
      check("digit_count", {29'h0, digit_count}, {29'h0, pend.cnt});
      check("num_valid", {31'h0, num_valid}, {31'h0, pend.nv});
      check("strobe width", {31'h0, key_strobe}, 32'h0);
      pending = 1'b0;
    end else begin
      if (num_valid) check("stray num_valid", {31'h0, num_valid}, 32'h0);
      if (key_strobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected strobe", {28'h0, key_code}, 32'hFFFF);
        end else begin
          pend = exp_q.pop_front();
          check("key_code", {28'h0, key_code}, {28'h0, pend.code});
          pending = 1'b1;
        end
      end
    end
  end

  task automatic press(input int r, input int c, input logic [3:0] code,
                       input logic [15:0] bcd, input logic [2:0] cnt, input logic nv);
    exp_q.push_back({code, bcd, cnt, nv});
    pressed[r*4+c] = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    pressed = '0;
    repeat (3 * FRAME) @(negedge clk);
  endtask

  task automatic wait_row(input logic [3:0] target);
    int n;
    n = 0;
    while (row !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("row wait timeout", {28'h0, row}, {28'h0, target});
  endtask

  initial begin
    logic [3:0] er;
    int cyc;

    repeat (3) @(negedge clk);
    check("reset row", {28'h0, row}, 32'h1);
    check("reset key_code", {28'h0, key_code}, 32'h0);
    check("reset key_strobe", {31'h0, key_strobe}, 32'h0);
    check("reset bcd", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h0);
    check("reset digit_count", {29'h0, digit_count}, 32'h0);
    check("reset num_valid", {31'h0, num_valid}, 32'h0);
    rst = 1'b0;

    for (int k = 0; k < 64; k++) begin
      er = 4'b0001 << ((k / 4) % 4);
      check("row scan", {28'h0, row}, {28'h0, er});
      @(negedge clk);
    end

    press(1, 1, 4'h5, 16'h0005, 3'd1, 1'b0);
    press(3, 0, 4'hE, 16'h0000, 3'd0, 1'b0);
    press(0, 0, 4'h1, 16'h0001, 3'd1, 1'b0);
    press(0, 1, 4'h2, 16'h0012, 3'd2, 1'b0);
    press(0, 2, 4'h3, 16'h0123, 3'd3, 1'b0);
    press(1, 0, 4'h4, 16'h1234, 3'd4, 1'b0);
    press(1, 1, 4'h5, 16'h1234, 3'd4, 1'b0);
    press(3, 2, 4'hF, 16'h1234, 3'd4, 1'b1);
    press(2, 0, 4'h7, 16'h0007, 3'd1, 1'b0);

    // 8 and 9 together is MULTI; dropping 9 leaves a clean 8.
    pressed[9]  = 1'b1;
    pressed[10] = 1'b1;
    repeat (4 * FRAME) @(negedge clk);
    exp_q.push_back({4'h8, 16'h0078, 3'd2, 1'b0});
    pressed[10] = 1'b0;
    repeat (3 * FRAME) @(negedge clk);
    pressed = '0;
    repeat (3 * FRAME) @(negedge clk);

    press(1, 0, 4'h4, 16'h0784, 3'd3, 1'b0);
    press(0, 1, 4'h2, 16'h7842, 3'd4, 1'b0);
    press(3, 0, 4'hE, 16'h0000, 3'd0, 1'b0);

    // Reset while "6" is mid-debounce.
    pressed[6] = 1'b1;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst key_code", {28'h0, key_code}, 32'h0);
    check("rst row", {28'h0, row}, 32'h1);
    exp_q.push_back({4'h6, 16'h0006, 3'd1, 1'b0});
    rst = 1'b0;
    cyc = 0;
    while (!key_strobe && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("strobe latency after reset", cyc, 32);
    repeat (2 * FRAME) @(negedge clk);
    pressed = '0;
    repeat (3 * FRAME) @(negedge clk);

    // Chatter on key 1, frame-aligned, then a stable hold.
    wait_row(4'b1000);
    wait_row(4'b0001);
    for (int i = 0; i < 4; i++) begin
      pressed[0] = (i % 2 == 0);
      repeat (FRAME) @(negedge clk);
    end
    exp_q.push_back({4'h1, 16'h0061, 3'd2, 1'b0});
    pressed[0] = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    pressed = '0;
    repeat (3 * FRAME) @(negedge clk);

    check("strobes outstanding", exp_q.size(), 0);
    check("entry check outstanding", {31'h0, pending}, 32'h0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
